// File: rtl/key_pkg.sv
// key_pkg: shared types and default constants for the push-button debouncer.
//   key_state_t   - debounce FSM state encoding
//   Default*      - default parameter values (50 MHz system clock)
//   key_max()     - helper used to size the auto-repeat timer
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } key_state_t;

  localparam int unsigned DefaultDebounceCycles = 500000;    // 10 ms
  localparam int unsigned DefaultRepeatDelay    = 25000000;  // 500 ms
  localparam int unsigned DefaultRepeatPeriod   = 5000000;   // 100 ms

  function automatic int unsigned key_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: N-flop synchronizer for a single asynchronous bit.
//   clk     - destination clock
//   rst     - synchronous active-low reset
//   rst_val - value every flop takes during reset
//   d       - asynchronous input
//   q       - synchronized output (last flop of the chain)
module key_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain_q <= {N{rst_val}};
    end else begin
      chain_q <= {chain_q[N-2:0], d};
    end
  end

  assign q = chain_q[N-1];

endmodule

// File: rtl/key_down_detector.sv
// key_down_detector: debounces one raw active-low push-button.
//   clk             - system clock
//   rst             - synchronous active-low reset
//   i_key_n         - raw button, 0 = pressed, asynchronous, may bounce
//   o_down_detected - one-cycle pulse per accepted press (and per repeat)
//   o_up_detected   - one-cycle pulse per accepted release
//   o_pressed       - debounced level, 1 = held
// Optional feature: define KEY_AUTO_REPEAT_EN to add auto-repeat pulses while
// the key is held (REPEAT_DELAY to the first repeat, then every REPEAT_PERIOD).
module key_down_detector
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_W           = 20
`ifdef KEY_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = DefaultRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefaultRepeatPeriod
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_down_detected,
  output logic o_up_detected,
  output logic o_pressed
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       sync2;
  logic       key_s;
  key_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       down_q, down_d;
  logic       up_q, up_d;

  // Flops reset to 1 so a reset never looks like a press.
  key_sync #(
    .N (2)
  ) u_key_sync (
    .clk     (clk),
    .rst     (rst),
    .rst_val (1'b1),
    .d       (i_key_n),
    .q       (sync2)
  );

  assign key_s = ~sync2;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned RptW = $clog2(key_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

  logic [RptW-1:0] rpt_q, rpt_d;
  logic            first_q, first_d;  // still waiting for the first repeat
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    down_d  = 1'b0;
    up_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = PRESSED;
          cnt_d   = '0;
          down_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = IDLE;
          cnt_d   = '0;
          up_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef KEY_AUTO_REPEAT_EN
    rpt_d   = rpt_q;
    first_d = first_q;
    if (state_q == PRESS_CHK && state_d == PRESSED) begin
      rpt_d   = '0;
      first_d = 1'b1;
    end else if ((state_q == PRESSED || state_q == RELEASE_CHK) && state_d != IDLE) begin
      // Leaving for IDLE freezes the timer, which also keeps a repeat pulse
      // from ever coinciding with the release pulse.
      if (rpt_q == (first_q ? DelayLast : PeriodLast)) begin
        rpt_d   = '0;
        first_d = 1'b0;
        down_d  = 1'b1;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

`ifdef KEY_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end
`endif

  assign o_down_detected = down_q;
  assign o_up_detected   = up_q;
  assign o_pressed       = (state_q == PRESSED) || (state_q == RELEASE_CHK);

endmodule

// File: doc/key_down_detector.md
# key_down_detector

Debounces one raw active-low DE2-115 push-button and produces a single-cycle `o_down_detected` pulse per accepted press. It sits directly upstream of the seven-segment decoder and drives that decoder's `down_detected` input, which advances the decoder's press counter. It also provides a debounced level, a release pulse and an optional auto-repeat.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000 — cycles the key must stay stable before a change is accepted (10 ms at 50 MHz); legal range is ≥ 2.
- `CNT_W`, 20 — debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `REPEAT_DELAY`, 25000000 — cycles from the first pulse to the first repeat pulse. Present only with `KEY_AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, 5000000 — cycles between successive repeat pulses. Present only with `KEY_AUTO_REPEAT_EN`.

Ports:
- `clk`  in  1  — system clock, single domain.
- `rst`  in  1  — reset; synchronous, active-low.
- `i_key_n`  in  1  — raw button, 0 = pressed; asynchronous to `clk`, may bounce.
- `o_down_detected`  out  1  — one-cycle pulse per accepted press (and per repeat when enabled).
- `o_up_detected`  out  1  — one-cycle pulse per accepted release.
- `o_pressed`  out  1  — debounced level, 1 = held.

## Operation
- **Synchronizer:** two flops on `i_key_n`, both reset to 1. Define `key_s = ~sync2`.
- **FSM states:** IDLE, PRESS_CHK, PRESSED, RELEASE_CHK. Reset state is IDLE.
- **IDLE:**
  - `key_s` = 1 → PRESS_CHK, `cnt` = 0.
  - Otherwise stay in IDLE.
- **PRESS_CHK:**
  - `key_s` = 0 → IDLE. This is a bounce; no pulse.
  - `key_s` = 1 and `cnt` = DEBOUNCE_CYCLES-1 → PRESSED; register `o_down_detected` = 1.
  - Otherwise `cnt`++.
- **PRESSED:**
  - `key_s` = 0 → RELEASE_CHK, `cnt` = 0.
- **RELEASE_CHK:**
  - `key_s` = 1 → PRESSED. This is a bounce; no pulse, and the repeat timer is not reset.
  - `key_s` = 0 and `cnt` = DEBOUNCE_CYCLES-1 → IDLE; register `o_up_detected` = 1.
  - Otherwise `cnt`++.
- **`o_pressed`:** 1 in PRESSED and RELEASE_CHK, 0 otherwise.
- **Pulse outputs:** `o_down_detected` and `o_up_detected` are registered and default to 0 every cycle. They are never high together.
- **Counter:** `cnt` is CNT_W bits unsigned. It is cleared on every state entry and never wraps, because it stops at DEBOUNCE_CYCLES-1.

## Timing
- **Reset values:** all outputs 0, `cnt` 0, sync flops 1, state IDLE.
- **Reset mid-operation:** returns to IDLE immediately, with no pulse.
- **Key held through reset release:** the press is reported after the full debounce.
- **Press latency:** `i_key_n` falls before clock edge E0 and stays low. Then `o_down_detected` is high for exactly the cycle following edge E0+DEBOUNCE_CYCLES+2.
- **Release latency:** same formula as press latency.
- **Bounce filtering:** any bounce shorter than DEBOUNCE_CYCLES cycles produces no pulse and no change of `o_pressed`.
- **Minimum pulse spacing:** two accepted presses are at least 2·(DEBOUNCE_CYCLES+1) cycles apart.

## Configuration
- **`KEY_AUTO_REPEAT_EN` defined:** a repeat timer starts at 0 on entry to PRESSED from PRESS_CHK.
  - When the timer reaches REPEAT_DELAY-1, pulse `o_down_detected` and reload the timer to 0.
  - After that, pulse every REPEAT_PERIOD cycles while the FSM stays in PRESSED or RELEASE_CHK.
  - The timer holds and stops pulsing on entry to IDLE.
- **`KEY_AUTO_REPEAT_EN` undefined:** exactly one `o_down_detected` pulse per press. The repeat parameters and timer logic are absent.

## Structure
- **Package `key_pkg`:**
  - `typedef enum logic [1:0] key_state_t` {IDLE, PRESS_CHK, PRESSED, RELEASE_CHK}.
  - Default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
- **Sub-module `key_sync`:** parameterizable N-flop synchronizer with a reset value input, instantiated with N = 2. The rest of the logic is a single FSM plus counters.

## Test plan
All cases use DEBOUNCE_CYCLES = 4; the repeat cases use REPEAT_DELAY = 10 and REPEAT_PERIOD = 3.
- **Clean press:** drive `i_key_n` low before edge 0 and hold it → `o_down_detected` is high for one cycle after edge 6. `o_pressed` is 1 from edge 6 on.
- **Bounce:** low 2 cycles, high 1, low 2, high → no pulse and `o_pressed` stays 0. Then holding low yields exactly one pulse.
- **Release:** release after a press → `o_up_detected` one-cycle pulse 6 edges after the release edge. `o_pressed` drops in the same cycle. No `o_down_detected` occurs.
- **Reset in PRESS_CHK:** `rst` = 0 for 1 cycle at edge 4 → no pulse and the state is IDLE. The key is still held, so the pulse arrives 6 edges after reset deasserts.
- **Auto-repeat (`KEY_AUTO_REPEAT_EN`):** hold for 30 cycles after the first pulse → repeat pulses 10, 13, 16 … cycles after it. Releasing stops them.
- **No auto-repeat (`KEY_AUTO_REPEAT_EN` undefined):** same 30-cycle hold → exactly one `o_down_detected` pulse.
